// File: rtl/spi_ram_arbiter_pkg.sv
// Shared definitions for the SPI RAM arbiter.
//  - CMD_READ_DEFAULT : SPI RAM READ command byte sent for DMA bursts
//  - arb_state_t      : arbiter FSM state encoding (also visible on dbg_state)
//  - seg_t            : burst segment tracked inside the shift engine
//  - max_int          : helper for sizing counters
package spi_ram_arbiter_pkg;

    localparam logic [7:0] CMD_READ_DEFAULT = 8'h03;

    typedef enum logic [2:0] {
        ST_CPU       = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_GAP       = 3'd2,
        ST_CMD       = 3'd3,
        ST_ADDR      = 3'd4,
        ST_LAT       = 3'd5,
        ST_DATA      = 3'd6,
        ST_END       = 3'd7
    } arb_state_t;

    typedef enum logic [1:0] {
        SEG_CMD  = 2'd0,
        SEG_ADDR = 2'd1,
        SEG_LAT  = 2'd2,
        SEG_DATA = 2'd3
    } seg_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_spi_shift_engine.sv
// spi_shift_engine: serialises one SPI RAM READ burst, one bit per cycle.
//  Sequence after load: 8 command bits, ADDR_BITS address bits (both MSB
//  first on mosi), DATA_LATENCY turnaround bits (mosi=0, miso ignored), then
//  8*len data bits shifted in from miso MSB first.
// Ports:
//  cpu_clk, rstn      clock, synchronous active-low reset
//  load               1-cycle pulse: capture cmd/addr/len and start the burst
//  cmd, addr, len     burst description (len=0 means 2**LEN_BITS bytes)
//  miso               serial data from the RAM
//  mosi               serial data to the RAM for the current bit
//  seg_last           current cycle is the last bit of the current segment
//  finish             current cycle is the last data bit of the burst
//  byte_data          last received byte
//  byte_valid         1-cycle strobe, high in the cycle byte_data changes
// DATA_LATENCY must be at least 1.
module spi_shift_engine
    import spi_ram_arbiter_pkg::*;
#(
    parameter int ADDR_BITS    = 24,
    parameter int LEN_BITS     = 8,
    parameter int DATA_LATENCY = 2
) (
    input  logic                 cpu_clk,
    input  logic                 rstn,
    input  logic                 load,
    input  logic [7:0]           cmd,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [LEN_BITS-1:0]  len,
    input  logic                 miso,
    output logic                 mosi,
    output logic                 seg_last,
    output logic                 finish,
    output logic [7:0]           byte_data,
    output logic                 byte_valid
);

    // One counter serves every segment, so it must reach both the address
    // length and the full data length of 8 * 2**LEN_BITS bits.
    localparam int CW = max_int(LEN_BITS + 3,
                                max_int($clog2(ADDR_BITS) + 1, $clog2(DATA_LATENCY) + 1));
    localparam int SW = 8 + ADDR_BITS;

    logic                  active;
    seg_t                  seg;
    logic [CW-1:0]         cnt;
    logic [SW-1:0]         sh;
    logic [LEN_BITS+2:0]   data_last;
    logic [6:0]            rx;
    logic [LEN_BITS-1:0]   len_m1;

    // len - 1 wraps 0 to all ones, which gives the 2**LEN_BITS byte case for free.
    assign len_m1 = len - LEN_BITS'(1);

    always_comb begin
        seg_last = 1'b0;
        case (seg)
            SEG_CMD:  seg_last = (cnt == CW'(7));
            SEG_ADDR: seg_last = (cnt == CW'(ADDR_BITS - 1));
            SEG_LAT:  seg_last = (cnt == CW'(DATA_LATENCY - 1));
            SEG_DATA: seg_last = (cnt == CW'(data_last));
            default:  seg_last = 1'b0;
        endcase
        seg_last = seg_last & active;
    end

    assign finish = seg_last & (seg == SEG_DATA);
    assign mosi   = active & ((seg == SEG_CMD) | (seg == SEG_ADDR)) & sh[SW-1];

    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            active     <= 1'b0;
            seg        <= SEG_CMD;
            cnt        <= '0;
            sh         <= '0;
            data_last  <= '0;
            rx         <= '0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (load) begin
                active    <= 1'b1;
                seg       <= SEG_CMD;
                cnt       <= '0;
                sh        <= {cmd, addr};
                data_last <= {len_m1, 3'b111};
            end else if (active) begin
                if (seg_last) begin
                    cnt <= '0;
                    if (seg == SEG_DATA) begin
                        active <= 1'b0;
                    end else begin
                        seg <= seg_t'(seg + 2'd1);
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                if ((seg == SEG_CMD) || (seg == SEG_ADDR)) begin
                    sh <= {sh[SW-2:0], 1'b0};
                end
                // The data counter starts at 0, so its low 3 bits mark byte ends.
                if (seg == SEG_DATA) begin
                    rx <= {rx[5:0], miso};
                    if (cnt[2:0] == 3'b111) begin
                        byte_data  <= {rx, miso};
                        byte_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares the SPI RAM port between the nanoV CPU and a
// block-read DMA requester. The CPU owns the bus by default and its signals
// pass straight through. A DMA request is granted only when the CPU has
// select high; the CPU is then held via cpu_hold while the arbiter runs its
// own 03h READ burst and streams bytes on dma_data/dma_data_valid.
// Ports:
//  cpu_clk, rstn                          clock, synchronous active-low reset
//  cpu_spi_select/mosi/clk_enable         CPU SPI outputs (select active low)
//  cpu_hold                               1 = CPU must not advance
//  spi_miso                               buffered MISO from the pad
//  spi_select_out/mosi_out/clk_enable_out to the pad registers / SCK gating
//  dma_req, dma_addr, dma_len             request pulse and its burst description
//  dma_busy                               request accepted, burst not yet done
//  dma_data, dma_data_valid               received byte and its 1-cycle strobe
//  dma_done                               1-cycle strobe after the burst, select high
//  dbg_state                              current arbiter state (arb_state_t)
// Request handshake: dma_req is a 1-cycle pulse with no ready; it is taken
// only when dma_busy=0 (dma_addr/dma_len sampled in that cycle) and ignored
// otherwise. Each accepted request yields exactly len bytes and one dma_done,
// unless rstn intervenes.
module spi_ram_arbiter
    import spi_ram_arbiter_pkg::*;
#(
    parameter int         ADDR_BITS    = 24,
    parameter int         LEN_BITS     = 8,
    parameter logic [7:0] CMD_READ     = CMD_READ_DEFAULT,
    parameter int         DATA_LATENCY = 2
) (
    input  logic                 cpu_clk,
    input  logic                 rstn,
    input  logic                 cpu_spi_select,
    input  logic                 cpu_spi_mosi,
    input  logic                 cpu_spi_clk_enable,
    output logic                 cpu_hold,
    input  logic                 spi_miso,
    output logic                 spi_select_out,
    output logic                 spi_mosi_out,
    output logic                 spi_clk_enable_out,
    input  logic                 dma_req,
    input  logic [ADDR_BITS-1:0] dma_addr,
    input  logic [LEN_BITS-1:0]  dma_len,
    output logic                 dma_busy,
    output logic [7:0]           dma_data,
    output logic                 dma_data_valid,
    output logic                 dma_done,
    output logic [2:0]           dbg_state
);

    arb_state_t           state;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  len_q;
    logic                 eng_load;
    logic                 eng_mosi;
    logic                 eng_seg_last;
    logic                 eng_finish;
    logic                 cpu_owns;

    assign cpu_owns  = (state == ST_CPU) || (state == ST_WAIT_IDLE);
    assign eng_load  = (state == ST_GAP);
    assign dbg_state = state;

    // The combinational grant term keeps the CPU from opening a transaction
    // in the very cycle the bus is handed to the DMA path.
    assign cpu_hold = rstn & (~cpu_owns |
                              ((state == ST_CPU) & dma_req & cpu_spi_select & ~dma_busy));

    spi_shift_engine #(
        .ADDR_BITS    (ADDR_BITS),
        .LEN_BITS     (LEN_BITS),
        .DATA_LATENCY (DATA_LATENCY)
    ) u_engine (
        .cpu_clk    (cpu_clk),
        .rstn       (rstn),
        .load       (eng_load),
        .cmd        (CMD_READ),
        .addr       (addr_q),
        .len        (len_q),
        .miso       (spi_miso),
        .mosi       (eng_mosi),
        .seg_last   (eng_seg_last),
        .finish     (eng_finish),
        .byte_data  (dma_data),
        .byte_valid (dma_data_valid)
    );

    always_ff @(posedge cpu_clk) begin
        if (!rstn) begin
            state    <= ST_CPU;
            addr_q   <= '0;
            len_q    <= '0;
            dma_busy <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                ST_CPU: begin
                    if (dma_req && !dma_busy) begin
                        addr_q   <= dma_addr;
                        len_q    <= dma_len;
                        dma_busy <= 1'b1;
                        state    <= cpu_spi_select ? ST_GAP : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    // Never cut into a CPU transaction: wait for select high.
                    if (cpu_spi_select) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP:  state <= ST_CMD;
                ST_CMD:  if (eng_seg_last) state <= ST_ADDR;
                ST_ADDR: if (eng_seg_last) state <= ST_LAT;
                ST_LAT:  if (eng_seg_last) state <= ST_DATA;
                ST_DATA: if (eng_finish)   state <= ST_END;
                ST_END: begin
                    dma_busy <= 1'b0;
                    dma_done <= 1'b1;
                    state    <= ST_CPU;
                end
                default: state <= ST_CPU;
            endcase
        end
    end

    // Output mux: CPU pass-through while it owns the bus, burst framing
    // otherwise. Select is forced high whenever reset is asserted.
    always_comb begin
        spi_select_out     = 1'b1;
        spi_mosi_out       = 1'b0;
        spi_clk_enable_out = 1'b0;
        case (state)
            ST_CPU, ST_WAIT_IDLE: begin
                spi_select_out     = cpu_spi_select;
                spi_mosi_out       = cpu_spi_mosi;
                spi_clk_enable_out = cpu_spi_clk_enable;
            end
            ST_GAP, ST_END: begin
                spi_select_out     = 1'b1;
                spi_clk_enable_out = 1'b0;
            end
            default: begin
                spi_select_out     = 1'b0;
                spi_clk_enable_out = 1'b1;
                spi_mosi_out       = eng_mosi;
            end
        endcase
        if (!rstn) begin
            spi_select_out = 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Testbench for spi_ram_arbiter: SPI RAM model, CPU/DMA driver tasks,
// byte scoreboard, pass-through vector table and burst corner sequences.
module tb_spi_ram_arbiter;
    import spi_ram_arbiter_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cpu_spi_select = 1'b1;
    logic        cpu_spi_mosi = 1'b0;
    logic        cpu_spi_clk_enable = 1'b0;
    logic        cpu_hold;
    logic        spi_miso = 1'b0;
    logic        spi_select_out;
    logic        spi_mosi_out;
    logic        spi_clk_enable_out;
    logic        dma_req = 1'b0;
    logic [23:0] dma_addr = 24'h0;
    logic [7:0]  dma_len = 8'h0;
    logic        dma_busy;
    logic [7:0]  dma_data;
    logic        dma_data_valid;
    logic        dma_done;
    logic [2:0]  dbg_state;

    spi_ram_arbiter dut (
        .cpu_clk            (cpu_clk),
        .rstn               (rstn),
        .cpu_spi_select     (cpu_spi_select),
        .cpu_spi_mosi       (cpu_spi_mosi),
        .cpu_spi_clk_enable (cpu_spi_clk_enable),
        .cpu_hold           (cpu_hold),
        .spi_miso           (spi_miso),
        .spi_select_out     (spi_select_out),
        .spi_mosi_out       (spi_mosi_out),
        .spi_clk_enable_out (spi_clk_enable_out),
        .dma_req            (dma_req),
        .dma_addr           (dma_addr),
        .dma_len            (dma_len),
        .dma_busy           (dma_busy),
        .dma_data           (dma_data),
        .dma_data_valid     (dma_data_valid),
        .dma_done           (dma_done),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / check ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [23:0] t;
        if (a == 24'h000100) return 8'hA5;
        if (a == 24'h000101) return 8'h3C;
        t = a * 24'd37 + 24'h5B;
        return t[7:0];
    endfunction

    // ---------------- SPI RAM model ----------------
    // Bit i of a transaction (select low, clock enabled): 0..31 command and
    // address, 32..33 turnaround, 34.. data, MSB first.
    int          bit_n = 0;
    int          last_bits = 0;
    int          txn_cnt = 0;
    logic [31:0] cap = 32'h0;
    logic [7:0]  last_cmd = 8'h0;
    logic [23:0] last_addr = 24'h0;

    always @(negedge cpu_clk) begin
        int          k;
        logic [7:0]  b;
        if (spi_select_out) begin
            if (bit_n != 0) begin
                last_bits = bit_n;
                last_cmd  = cap[31:24];
                last_addr = cap[23:0];
                txn_cnt++;
            end
            bit_n    = 0;
            spi_miso = 1'b0;
        end else if (spi_clk_enable_out) begin
            if (bit_n >= 34) begin
                k = bit_n - 34;
                b = mem_byte(cap[23:0] + 24'(k / 8));
                spi_miso = b[7 - (k % 8)];
            end else begin
                spi_miso = 1'b0;
            end
            if (bit_n < 32) cap = {cap[30:0], spi_mosi_out};
            bit_n++;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         valid_cnt = 0;
    int         done_cnt = 0;
    logic       prev_valid = 1'b0;

    always @(negedge cpu_clk) begin
        logic [7:0] e;
        if (dma_data_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("dma_unexpected_byte", {24'h0, dma_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("dma_data", {24'h0, dma_data}, {24'h0, e});
            end
        end
        if (dma_done) begin
            done_cnt++;
            chk("done_after_valid", {31'h0, prev_valid}, 32'h1);
        end
        prev_valid = dma_data_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic dma_issue(input logic [23:0] a, input logic [7:0] l);
        int nb;
        nb = (l == 8'h0) ? 256 : int'(l);
        for (int k = 0; k < nb; k++) exp_q.push_back(mem_byte(a + 24'(k)));
        dma_req  = 1'b1;
        dma_addr = a;
        dma_len  = l;
    endtask

    task automatic cpu_read(input logic [23:0] a, input int n);
        logic [31:0] hdr;
        logic [7:0]  b;
        hdr = {8'h03, a};
        b   = 8'h0;
        cpu_spi_select     = 1'b0;
        cpu_spi_clk_enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            cpu_spi_mosi = hdr[31 - i];
            tick();
        end
        cpu_spi_mosi = 1'b0;
        tick();
        tick();
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge cpu_clk);
                #1;
                b = {b[6:0], spi_miso};
                tick();
            end
            chk("cpu_rd_byte", {24'h0, b}, {24'h0, mem_byte(a + 24'(j))});
        end
        cpu_spi_select     = 1'b1;
        cpu_spi_clk_enable = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int c;
        c = 0;
        while (!dma_done && c < budget) begin
            tick();
            c++;
        end
        chk({nm, "_done_seen"}, {31'h0, dma_done}, 32'h1);
    endtask

    task automatic wait_state(input arb_state_t s, input int budget);
        int c;
        c = 0;
        while (dbg_state != s && c < budget) begin
            tick();
            c++;
        end
        chk("wait_state", {29'h0, dbg_state}, {29'h0, s});
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic       rstn;
        logic       sel;
        logic       mosi;
        logic       clken;
        logic [3:0] exp;   // {select_out, mosi_out, clk_enable_out, cpu_hold}
    } pt_vec_t;

    typedef struct {
        logic [23:0] a;
        logic [7:0]  l;
    } burst_t;

    pt_vec_t pt[7];
    burst_t  bt[3];

    initial begin
        int v0, d0, t0;

        pt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1000};
        pt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0110};
        pt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0010};
        pt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1100};
        pt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b1110};
        pt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
        pt[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0100};
        bt[0] = '{24'h000010, 8'd1};
        bt[1] = '{24'h0ABCDE, 8'd3};
        bt[2] = '{24'hFFFFFE, 8'd2};

        // reset
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_hold",  {31'h0, cpu_hold}, 32'h0);
        chk("rst_busy",  {31'h0, dma_busy}, 32'h0);
        chk("rst_data",  {24'h0, dma_data}, 32'h0);
        chk("rst_valid", {31'h0, dma_data_valid}, 32'h0);
        chk("rst_done",  {31'h0, dma_done}, 32'h0);
        chk("rst_state", {29'h0, dbg_state}, {29'h0, ST_CPU});
        chk("rst_sel",   {31'h0, spi_select_out}, 32'h1);
        rstn = 1'b1;
        tick();

        // pass-through table (CPU owner, no request)
        for (int i = 0; i < 7; i++) begin
            rstn = pt[i].rstn;
            cpu_spi_select = pt[i].sel;
            cpu_spi_mosi = pt[i].mosi;
            cpu_spi_clk_enable = pt[i].clken;
            #1;
            chk("pass_vec", {28'h0, spi_select_out, spi_mosi_out, spi_clk_enable_out, cpu_hold},
                {28'h0, pt[i].exp});
            tick();
        end
        rstn = 1'b1;
        cpu_spi_select = 1'b1;
        cpu_spi_mosi = 1'b0;
        cpu_spi_clk_enable = 1'b0;
        tick();

        // 1: idle CPU, 2-byte burst
        v0 = valid_cnt;
        dma_issue(24'h000100, 8'd2);
        #1;
        chk("t1_hold_grant", {31'h0, cpu_hold}, 32'h1);
        tick();
        dma_req = 1'b0;
        chk("t1_gap_state", {29'h0, dbg_state}, {29'h0, ST_GAP});
        chk("t1_gap_bus", {30'h0, spi_select_out, spi_clk_enable_out}, 32'h2);
        tick();
        chk("t1_cmd_sel", {31'h0, spi_select_out}, 32'h0);
        wait_done(200, "t1");
        chk("t1_cmd", {24'h0, last_cmd}, 32'h03);
        chk("t1_addr", {8'h0, last_addr}, 32'h000100);
        chk("t1_bits", last_bits, 32 + 2 + 16);
        chk("t1_nbytes", valid_cnt - v0, 2);
        chk("t1_hold_after", {31'h0, cpu_hold}, 32'h0);
        chk("t1_busy_after", {31'h0, dma_busy}, 32'h0);
        tick();

        // 2: request during a CPU read
        fork
            cpu_read(24'h000123, 2);
            begin
                repeat (10) tick();
                dma_issue(24'h000101, 8'd1);
                tick();
                dma_req = 1'b0;
                chk("t2_wait_state", {29'h0, dbg_state}, {29'h0, ST_WAIT_IDLE});
                chk("t2_wait_hold", {31'h0, cpu_hold}, 32'h0);
            end
        join
        chk("t2_still_wait", {29'h0, dbg_state}, {29'h0, ST_WAIT_IDLE});
        tick();
        chk("t2_gap_state", {29'h0, dbg_state}, {29'h0, ST_GAP});
        chk("t2_gap_hold", {31'h0, cpu_hold}, 32'h1);
        wait_done(200, "t2");
        chk("t2_addr", {8'h0, last_addr}, 32'h000101);
        tick();

        // 3: len=0 -> 256 bytes
        v0 = valid_cnt;
        dma_issue(24'h000200, 8'd0);
        tick();
        dma_req = 1'b0;
        wait_done(3000, "t3");
        chk("t3_nbytes", valid_cnt - v0, 256);
        chk("t3_bits", last_bits, 8 + 24 + 2 + 2048);
        tick();

        // 4: second request during burst is ignored
        v0 = valid_cnt;
        d0 = done_cnt;
        dma_issue(24'h000300, 8'd3);
        tick();
        dma_req = 1'b0;
        wait_state(ST_DATA, 100);
        dma_req = 1'b1;
        dma_addr = 24'h000555;
        dma_len = 8'd9;
        tick();
        dma_req = 1'b0;
        chk("t4_state", {29'h0, dbg_state}, {29'h0, ST_DATA});
        chk("t4_busy", {31'h0, dma_busy}, 32'h1);
        wait_done(200, "t4");
        repeat (5) tick();
        chk("t4_addr", {8'h0, last_addr}, 32'h000300);
        chk("t4_nbytes", valid_cnt - v0, 3);
        chk("t4_ndone", done_cnt - d0, 1);
        chk("t4_idle", {29'h0, dbg_state}, {29'h0, ST_CPU});

        // 5: reset during DATA
        d0 = done_cnt;
        dma_issue(24'h000040, 8'd4);
        tick();
        dma_req = 1'b0;
        wait_state(ST_DATA, 100);
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        chk("t5_sel_in_rst", {31'h0, spi_select_out}, 32'h1);
        tick();
        rstn = 1'b1;
        #1;
        chk("t5_sel", {31'h0, spi_select_out}, 32'h1);
        chk("t5_hold", {31'h0, cpu_hold}, 32'h0);
        chk("t5_busy", {31'h0, dma_busy}, 32'h0);
        chk("t5_state", {29'h0, dbg_state}, {29'h0, ST_CPU});
        chk("t5_data", {24'h0, dma_data}, 32'h0);
        repeat (4) tick();
        chk("t5_no_done", done_cnt - d0, 0);
        exp_q.delete();
        cpu_read(24'h000101, 2);
        tick();

        // 6: request in the cycle the CPU lowers select
        t0 = txn_cnt;
        dma_issue(24'h000777, 8'd1);
        fork
            cpu_read(24'h0010A0, 1);
            begin
                tick();
                dma_req = 1'b0;
                chk("t6_wait_state", {29'h0, dbg_state}, {29'h0, ST_WAIT_IDLE});
            end
        join
        tick();
        chk("t6_gap_state", {29'h0, dbg_state}, {29'h0, ST_GAP});
        wait_done(200, "t6");
        chk("t6_txns", txn_cnt - t0, 2);
        chk("t6_addr", {8'h0, last_addr}, 32'h000777);
        tick();

        // extra bursts from a table
        for (int i = 0; i < 3; i++) begin
            v0 = valid_cnt;
            dma_issue(bt[i].a, bt[i].l);
            tick();
            dma_req = 1'b0;
            wait_done(200, "tbl");
            chk("tbl_addr", {8'h0, last_addr}, {8'h0, bt[i].a});
            chk("tbl_nbytes", valid_cnt - v0, int'(bt[i].l));
            tick();
        end

        repeat (3) tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
